// File: rtl/vga_nbuf_charmem_pkg.sv
// ---------------------------------------------------------------------------
// vga_nbuf_charmem_pkg
//   Shared definitions for the N-buffer character memory: clear-engine FSM
//   state encoding and the default fill code (ASCII space).
// ---------------------------------------------------------------------------
package vga_nbuf_charmem_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    localparam logic [7:0] DEFAULT_FILL = 8'h20;

endpackage : vga_nbuf_charmem_pkg

// File: rtl/vga_nbuf_charmem_bram.sv
// ---------------------------------------------------------------------------
// vga_nbuf_charmem_bram
//   Simple dual-port RAM: one synchronous write port, one registered
//   read-first read port. Holds every buffer back to back.
// Ports
//   i_clk    clock
//   i_rst    async active-high reset (read register only)
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  read data, valid one cycle after i_raddr
// ---------------------------------------------------------------------------
module vga_nbuf_charmem_bram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // NOTE: the array has no reset branch so it maps onto block RAM; only
    // the read register is cleared.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // NOTE: non-blocking assignment makes a same-cycle read of the cell being
    // written return the old contents (read-first).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : vga_nbuf_charmem_bram

// File: rtl/vga_nbuf_charmem.sv
// ---------------------------------------------------------------------------
// vga_nbuf_charmem
//   N-buffer character memory between the ASCII writer and the VGA glyph
//   engine. The writer fills the back buffer while the display scans the
//   front buffer; swaps are latched and executed only on end-of-frame so the
//   picture never tears. A clear engine fills the back buffer with FILL.
// Ports
//   i_clk, i_rst        clock, async active-high reset
//   i_wr_addr/data/en   back-buffer write (ignored while o_clr_busy)
//   i_clr_req           pulse: fill back buffer with FILL
//   o_clr_busy          clear engine running (exactly DEPTH cycles)
//   i_swap_req          pulse: promote back buffer at next eof
//   o_swap_pending      swap latched, not yet executed
//   o_swap_done         high in the cycle a swap executes
//   i_rd_addr/o_rd_data display read, 1-cycle latency
//   i_eof               end-of-frame pulse
//   o_disp_buf          index of displayed buffer
// ---------------------------------------------------------------------------
module vga_nbuf_charmem
    import vga_nbuf_charmem_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 13,
    parameter int                NUM_BUFS = 2,
    parameter logic [DATA_W-1:0] FILL     = DATA_W'(DEFAULT_FILL),
    localparam int               BUF_W    = $clog2(NUM_BUFS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_en,
    input  logic              i_clr_req,
    output logic              o_clr_busy,
    input  logic              i_swap_req,
    output logic              o_swap_pending,
    output logic              o_swap_done,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_eof,
    output logic [BUF_W-1:0]  o_disp_buf
);

    localparam int PHYS_W = BUF_W + ADDR_W;

    clr_state_t         r_state;
    clr_state_t         w_state_nxt;
    logic [ADDR_W-1:0]  r_clr_cnt;
    logic [BUF_W-1:0]   r_disp_buf;
    logic               r_swap_pending;

    logic [BUF_W-1:0]   w_wbuf;
    logic               w_clr_busy;
    logic               w_swap_exec;
    logic               w_mem_we;
    logic [PHYS_W-1:0]  w_mem_waddr;
    logic [DATA_W-1:0]  w_mem_wdata;

    // NUM_BUFS is a power of two, so the natural BUF_W wrap is the modulo.
    assign w_wbuf     = r_disp_buf + 1'b1;
    assign w_clr_busy = (r_state == ST_CLEAR);

    // A request arriving together with eof executes immediately; a swap is
    // never allowed while the back buffer is still being cleared.
    assign w_swap_exec = i_eof && !w_clr_busy && (r_swap_pending || i_swap_req);

    // ------------------------------------------------------------------
    // Clear-engine FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clr_busy) begin
                // Wraps back to 0 after the last cell, ready for next clear.
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned (which would infer a latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_clr_req)  w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (&r_clr_cnt) w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Swap control
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_disp_buf     <= '0;
            r_swap_pending <= 1'b0;
        end else begin
            if (w_swap_exec) begin
                r_disp_buf     <= w_wbuf;
                r_swap_pending <= 1'b0;
            end else if (i_swap_req) begin
                r_swap_pending <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write mux: clear engine owns the write port while busy. Both sources
    // target the pre-swap back buffer in a swap cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_we    = i_wr_en;
        w_mem_waddr = {w_wbuf, i_wr_addr};
        w_mem_wdata = i_wr_data;
        if (w_clr_busy) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = {w_wbuf, r_clr_cnt};
            w_mem_wdata = FILL;
        end
    end

    vga_nbuf_charmem_bram #(
        .DATA_W (DATA_W),
        .ADDR_W (PHYS_W)
    ) u_bram (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdata (w_mem_wdata),
        .i_raddr ({r_disp_buf, i_rd_addr}),
        .o_rdata (o_rd_data)
    );

    assign o_clr_busy     = w_clr_busy;
    assign o_swap_pending = r_swap_pending;
    assign o_swap_done    = w_swap_exec;
    assign o_disp_buf     = r_disp_buf;

endmodule : vga_nbuf_charmem
